// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter and its edge synchronizer.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_FINISH
  } state_e;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_GATE_W      = 16;

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Multi-flop synchronizer for an asynchronous level followed by a rising-edge
// detector; emits a one-clock pulse per rising edge of the input.
module edge_sync
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic Clk,
  input  logic Reset,
  input  logic async_i,
  output logic edge_p_o
);

  // Depth below two gives no metastability protection, so clamp upward.
  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: flops use non-blocking assignments so every stage samples the
  // value its predecessor held before this edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign edge_p_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous input over a
// programmable number of clock cycles and presents the result with done/valid.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_W      = DEF_GATE_W,
  parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Fmeas,
  input  logic              Start,
  input  logic [GATE_W-1:0] Gate_len,
  output logic              Busy,
  output logic              Done,
  output logic              Valid,
  output logic              Overflow,
  output logic [CNT_W-1:0]  Count
);

  state_e             state_q, state_d;
  logic [GATE_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               edge_p;

  edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .async_i  (Fmeas),
    .edge_p_o (edge_p)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case leaves one unassigned and infers a latch.
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    count_d = count_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          win_d   = (Gate_len == '0) ? GATE_W'(1) : Gate_len;
          cnt_d   = '0;
          sat_d   = 1'b0;
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_GATE;
        end
      end
      ST_GATE: begin
        // An edge arriving with the counter already full is lost and flagged.
        if (edge_p) begin
          if (cnt_q == '1) sat_d = 1'b1;
          else             cnt_d = cnt_q + CNT_W'(1);
        end
        if (win_q == GATE_W'(1)) state_d = ST_FINISH;
        else                     win_d   = win_q - GATE_W'(1);
      end
      ST_FINISH: begin
        count_d = cnt_q;
        ovf_d   = sat_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy     = (state_q != ST_IDLE);
  assign Done     = (state_q == ST_FINISH);
  assign Valid    = valid_q;
  assign Overflow = ovf_q;
  assign Count    = count_q;

endmodule
